// File: rtl/cnn_pkg.sv
// cnn_pkg
//   Constants and helpers shared by the CNN post-processing blocks.
//   PKG_IN_W   : default width of signed convolution results.
//   PKG_DATA_W : default width of unsigned output pixels.
//   cnt_w()    : width of a counter that must hold 0..out_w-1.
package cnn_pkg;

  localparam int PKG_IN_W   = 32;
  localparam int PKG_DATA_W = 8;

  function automatic int cnt_w(input int out_w);
    return (out_w < 2) ? 1 : $clog2(out_w);
  endfunction

endpackage

// File: rtl/relu_pool_requant_requant.sv
// relu_requant
//   Right-shift requantisation with unsigned saturation, followed by the
//   output register of the pooling stage.
//   clk, rst    : clock, synchronous active-high reset
//   clear_i     : synchronous frame abort (same effect as rst)
//   m_i         : non-negative pooled maximum
//   m_valid_i   : m_i holds a completed pooling window this cycle
//   out_data_o  : sat(m >>> SHIFT), held between pulses
//   out_valid_o : one-cycle pulse per requantised pixel
module relu_requant
  import cnn_pkg::*;
#(
  parameter int IN_W   = PKG_IN_W,
  parameter int DATA_W = PKG_DATA_W,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic [IN_W-1:0]   m_i,
  input  logic              m_valid_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o
);

  localparam logic [IN_W-1:0] SAT_MAX = {{(IN_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic [IN_W-1:0]   shifted;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  // m_i is never negative, so a logical shift equals the arithmetic one.
  assign shifted = m_i >> SHIFT;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (m_valid_i) begin
      out_valid_d = 1'b1;
      out_data_d  = (shifted > SAT_MAX) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/relu_pool_requant.sv
// relu_pool_requant
//   Streaming ReLU + 2x2/stride-2 max-pool + shift/saturate requantiser for
//   an OUT_W x OUT_W raster of signed conv results (no backpressure).
//   clk, rst   : clock, synchronous active-high reset
//   clear      : synchronous frame abort/restart
//   in_data    : signed conv result, in_valid qualifies it
//   out_data   : pooled, requantised pixel, out_valid pulses once per pixel
//   frame_done : pulses the cycle after the last input of a frame
module relu_pool_requant
  import cnn_pkg::*;
#(
  parameter int OUT_W  = 3,
  parameter int DATA_W = PKG_DATA_W,
  parameter int IN_W   = PKG_IN_W,
  parameter int SHIFT  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   frame_done
);

  localparam int CNT_W    = cnt_w(OUT_W);
  localparam int PW       = OUT_W / 2;
  localparam int POOL_LIM = 2 * PW;
  localparam int LB_AW    = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W - 1);

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [IN_W-1:0]  hold_q, hold_d;
  logic             frame_done_q, frame_done_d;

  // One entry per pooled column: max of the top row of each window.
  logic [IN_W-1:0]  linebuf [PW];
  logic [IN_W-1:0]  lb_rd_q;
  logic [LB_AW-1:0] lb_idx;
  logic             lb_we, lb_re;

  logic             accept;
  logic             in_pool;
  logic [IN_W-1:0]  relu_r;
  logic [IN_W-1:0]  pair_max;
  logic [IN_W-1:0]  win_max;
  logic             m_valid;

  // An input coinciding with rst/clear is dropped.
  assign accept  = in_valid && !rst && !clear;
  assign relu_r  = in_data[IN_W-1] ? '0 : in_data;
  // With odd OUT_W the last row and column fall outside every window.
  assign in_pool = (int'(col_q) < POOL_LIM) && (int'(row_q) < POOL_LIM);
  assign lb_idx  = LB_AW'(col_q >> 1);

  assign pair_max = (relu_r > hold_q) ? relu_r : hold_q;
  assign win_max  = (lb_rd_q > pair_max) ? lb_rd_q : pair_max;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    lb_re        = 1'b0;
    m_valid      = 1'b0;
    if (accept) begin
      if (col_q == LAST) begin
        col_d = '0;
        if (row_q == LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + CNT_W'(1);
        end
      end else begin
        col_d = col_q + CNT_W'(1);
      end

      if (in_pool) begin
        if (!col_q[0]) begin
          hold_d = relu_r;
          // Prefetch the top-row max now so the buffer read is registered;
          // the entry was written during the previous (even) row.
          lb_re  = 1'b1;
        end else if (!row_q[0]) begin
          lb_we = 1'b1;
        end else begin
          m_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer: plain array, synchronous write, registered read.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_idx] <= pair_max;
    if (lb_re) lb_rd_q <= linebuf[lb_idx];
  end

  relu_requant #(
    .IN_W   (IN_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT)
  ) u_requant (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear),
    .m_i         (win_max),
    .m_valid_i   (m_valid),
    .out_data_o  (out_data),
    .out_valid_o (out_valid)
  );

  assign frame_done = frame_done_q;

endmodule

// File: doc/relu_pool_requant.md
Name: relu_pool_requant

Overview:
- Streaming post-processing stage directly downstream of the 3-filter processing unit.
- Consumes its 32-bit signed convolution results, which arrive in raster order over an OUT_W x OUT_W map, one per valid cycle, with arbitrary gaps and no backpressure.
- Applies ReLU, 2x2 stride-2 max-pooling and right-shift requantisation with unsigned saturation.
- Emits DATA_W-bit pixels suitable as image input for the next convolution layer.

Parameters:
- OUT_W, 3: side length of the incoming conv map (N_pixels-2); must be >= 2.
- DATA_W, 8: output pixel width, unsigned.
- IN_W, 32: input result width, signed.
- SHIFT, 0: arithmetic right-shift applied before saturation; range 0..IN_W-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- clear  input  1  synchronous frame abort/restart; same effect as rst on state.
- in_data  input  IN_W  signed conv result.
- in_valid  input  1  in_data valid this cycle.
- out_data  output  DATA_W  pooled, requantised pixel.
- out_valid  output  1  out_data valid (1-cycle pulse per pooled pixel).
- frame_done  output  1  1-cycle pulse when the last input of a frame has been accepted.

Behaviour:
- Reset/clear values: out_data=0, out_valid=0, frame_done=0, col=0, row=0, hold=0. Line-buffer contents are don't-care; they are always written before being read.
- rst and clear take priority over in_valid. An input arriving in the same cycle as rst or clear is dropped.
- Counters col, row advance only on in_valid:
  - col wraps at OUT_W-1, then row increments.
  - On row=OUT_W-1 and col=OUT_W-1, both wrap to 0 and frame_done pulses in the next cycle.
- ReLU per input: r = (in_data<0) ? 0 : in_data. All comparisons use r (non-negative, IN_W bits).
- PW = OUT_W/2 (floor). If OUT_W is odd, inputs with col=OUT_W-1 or row=OUT_W-1 are ReLU'd but otherwise ignored (still counted).
- Even col within the pooled region: hold <= r.
- Odd col, even row: linebuf[col>>1] <= max(hold, r). linebuf depth is PW entries, IN_W bits each.
- Odd col, odd row: m = max(linebuf[col>>1], hold, r).
  - Next cycle: out_valid=1 and out_data = sat(m >>> SHIFT), where sat clamps to 2^DATA_W-1.
- Latency: 1 clk from the fourth contributing input to out_valid.
- Output order: raster over the PW x PW pooled map. PW*PW outputs per frame.
- in_valid gaps of any length are tolerated, including between the rows of a pooling window. State holds while in_valid=0.
- out_valid and frame_done may assert in the same cycle (last pooled pixel when OUT_W is even).
- No backpressure: a downstream consumer must accept every out_valid pulse.

Decomposition:
- Shared package cnn_pkg: constants IN_W, DATA_W, and the function clog2-based counter width CNT_W = $clog2(OUT_W).
- Sub-module relu_requant (combinational + output register):
  - Inputs: m and SHIFT.
  - Output: saturated DATA_W value.
- The top holds the counters, hold register and linebuf.

Test Plan:
- OUT_W=4, SHIFT=0, inputs 0..15 raster, continuous valid -> outputs 5,7,13,15 in order; frame_done one cycle after input 15.
- OUT_W=4, all inputs -7 -> four outputs of 0. Repeat with one input per window at 300 -> 255 (saturated). With SHIFT=2 and 300 -> 75.
- OUT_W=3 (default), inputs 1..9 -> single output 5; inputs 3 and 6..9 produce no output; frame_done after input 9.
- OUT_W=4, insert 0-5 idle cycles between every input (random) -> same 5,7,13,15 sequence. Each output appears exactly 1 cycle after its completing input.
- OUT_W=4, assert clear after 6 inputs, then send a full frame 0..15 -> outputs 5,7,13,15 only; no stale output from the aborted frame. Repeat with rst.
- Back-to-back frames with no gap -> second frame's outputs correct; frame_done pulses exactly twice.
